// File: rtl/mux_arb_pkg.sv
// Shared types, default sizes and index helpers for the mux round-robin arbiter
// and its priority picker.
package mux_arb_pkg;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 8;
  localparam int DEF_BURST_LEN = 4;

  // (base + off) mod n; used for pointer advance and for un-rotating an offset.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// modulo N, via a double-width rotate followed by a priority encoder.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx,
  output logic            any_req
);

  logic [N-1:0] rot;
  int unsigned  off;

  always_comb begin
    rot = N'({req, req} >> ptr);
    off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = 32'(j);
    end
    any_req = |req;
    idx     = IDXW'(rot_idx(32'(ptr), off, N));
    grant   = any_req ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with a registered output slot.
// Define MUX_ARB_BURST_EN to let a requester keep the pointer for up to BURST_LEN grants.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int IDXW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready,
  output logic [IDXW-1:0] grant_idx
);

  state_t          state_p0, state_nxt;
  logic [IDXW-1:0] ptr_p0, ptr_nxt;
  logic [N-1:0]    pick_grant;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            slot_free;
  logic            xfer;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_p0),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign out_valid = (state_p0 == ST_FULL);
  assign slot_free = !out_valid || out_ready;
  // Gated by rst_n so no requester sees a handshake while reset is held.
  assign xfer      = slot_free && pick_any && rst_n;
  assign in_ready  = xfer ? pick_grant : '0;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready) state_nxt = xfer ? ST_FULL : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

`ifdef MUX_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] cnt_p0, cnt_nxt, cnt_inc;

  // A grant to the pointer owner extends its burst; any other winner starts a new one.
  always_comb begin
    ptr_nxt = ptr_p0;
    cnt_nxt = cnt_p0;
    cnt_inc = (pick_idx == ptr_p0) ? cnt_p0 + CW'(1) : CW'(1);
    if (xfer) begin
      if (cnt_inc >= CW'(BURST_LEN)) begin
        ptr_nxt = IDXW'(rot_idx(32'(pick_idx), 1, N));
        cnt_nxt = '0;
      end else begin
        ptr_nxt = pick_idx;
        cnt_nxt = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_p0 <= '0;
    else        cnt_p0 <= cnt_nxt;
  end
`else
  always_comb begin
    ptr_nxt = ptr_p0;
    if (xfer) ptr_nxt = IDXW'(rot_idx(32'(pick_idx), 1, N));
  end
`endif

  // Stage p0: output slot, FSM state and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0  <= ST_EMPTY;
      ptr_p0    <= '0;
      out_data  <= '0;
      grant_idx <= '0;
    end else begin
      state_p0 <= state_nxt;
      ptr_p0   <= ptr_nxt;
      if (xfer) begin
        out_data  <= in_data[pick_idx*W +: W];
        grant_idx <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8, BURST_LEN=4);
// define MUX_ARB_BURST_EN for both bench and RTL to exercise burst mode.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [1:0]    grant_idx;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.N(N), .W(W), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] g);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, "_data"},  32'(out_data),  32'(d));
    check_eq({tag, "_grant"}, 32'(grant_idx), 32'(g));
  endtask

`ifdef MUX_ARB_BURST_EN
  logic [1:0] burst_exp [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h44332211;
    out_ready = 1'b0;
    #3;
    check_out("rst0", 1'b0, 8'h00, 2'd0);
    check_eq("rst0_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MUX_ARB_BURST_EN
    in_valid  = 4'b0011;
    in_data   = 32'h00002B1A;
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check_out($sformatf("burst%0d", k), 1'b1, (burst_exp[k] == 2'd0) ? 8'h1A : 8'h2B, burst_exp[k]);
    end
    in_valid = 4'b0001;
    @(negedge clk);
    check_out("burst_drop", 1'b1, 8'h1A, 2'd0);
    in_valid = 4'b0011;
    #1;
    check_eq("burst_ptr0_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    check_out("burst_stay", 1'b1, 8'h1A, 2'd0);
    in_valid = 4'b0000;
    @(negedge clk);
`else
    // Single requester
    in_valid  = 4'b0100;
    in_data   = 32'h00A50000;
    out_ready = 1'b1;
    #1;
    check_eq("single_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    check_out("single", 1'b1, 8'hA5, 2'd2);
    in_valid = 4'b1111;
    in_data  = 32'h44332211;
    #1;
    check_eq("ptr3_ready", 32'(in_ready), 32'b1000);
    @(negedge clk);
    check_out("ptr3", 1'b1, 8'h44, 2'd3);

    // Fairness with all requesting
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_out($sformatf("fair%0d", k), 1'b1, 8'((k % 4 + 1) * 8'h11), 2'(k % 4));
    end

    // Backpressure
    in_valid = 4'b0001;
    in_data  = 32'h0000003C;
    @(negedge clk);
    check_out("load3c", 1'b1, 8'h3C, 2'd0);
    out_ready = 1'b0;
    in_valid  = 4'b1010;
    in_data   = 32'hD400B200;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("bp%0d_ready", k), 32'(in_ready), 32'h0);
      @(negedge clk);
      check_out($sformatf("bp%0d", k), 1'b1, 8'h3C, 2'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'b0010);
    @(negedge clk);
    check_out("reload", 1'b1, 8'hB2, 2'd1);
    check_eq("after_reload_ready", 32'(in_ready), 32'b1000);

    // Wrap / skip from ptr=3
    in_valid = 4'b0100;
    in_data  = 32'h00770000;
    #1;
    check_eq("to_ptr3_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    check_out("to_ptr3", 1'b1, 8'h77, 2'd2);
    in_valid = 4'b0011;
    in_data  = 32'h00002B1A;
    #1;
    check_eq("wrap_ready", 32'(in_ready), 32'b0001);
    @(negedge clk);
    check_out("wrap0", 1'b1, 8'h1A, 2'd0);
    check_eq("wrap1_ready", 32'(in_ready), 32'b0010);
    @(negedge clk);
    check_out("wrap1", 1'b1, 8'h2B, 2'd1);
    in_valid = 4'b0000;
    #1;
    check_eq("idle_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    check_out("drain", 1'b0, 8'h2B, 2'd1);
    @(negedge clk);
    check_out("empty_hold", 1'b0, 8'h2B, 2'd1);
`endif

    // Async reset with a full output slot
    in_valid  = 4'b0001;
    in_data   = 32'h0000005E;
    out_ready = 1'b0;
    @(negedge clk);
    check_out("pre_rst", 1'b1, 8'h5E, 2'd0);
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 8'h00, 2'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b1010;
    in_data  = 32'hD400B200;
    @(negedge clk);
    check_out("rst_hold", 1'b0, 8'h00, 2'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'b0010);
    @(negedge clk);
    check_out("post_rst", 1'b1, 8'hB2, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
